// File: rtl/ifetch_pkg.sv
// Shared types and constants for the instruction-fetch responder.
// Alignment mask and NOP filler for misaligned-fetch fault entries.
package ifetch_pkg;

  localparam int FETCH_XLEN = 32;
  localparam int FETCH_ILEN = 32;

  localparam logic [31:0] NOP        = 32'h0000_0013;
  localparam logic [1:0]  ALIGN_MASK = 2'b11;

  typedef struct packed {
    logic [FETCH_XLEN-1:0] pc;
    logic [FETCH_ILEN-1:0] inst;
    logic                  fault;
  } fetch_entry_t;

  function automatic logic is_misaligned(input logic [1:0] lo);
    return (lo & ALIGN_MASK) != 2'b00;
  endfunction

endpackage

// File: rtl/ifetch_fifo.sv
// Synchronous FIFO of fetch entries, 1-cycle write-to-read latency, clear wins over push/pop.
// No internal backpressure: the caller reserves slots ahead of time through its credit count.
module ifetch_fifo
  import ifetch_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       push,
  input  fetch_entry_t               push_dat,
  input  logic                       pop,
  input  logic                       clear,
  output fetch_entry_t               head,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       full,
  output logic                       empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  fetch_entry_t    mem [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;

  assign head  = mem[rd_ptr];
  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);

  always_ff @(posedge clock) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      // DEPTH is a power of two, so pointers wrap naturally
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clock) begin
    if (push) mem[wr_ptr] <= push_dat;
  end

endmodule

// File: rtl/ifetch_resp.sv
// Fetch responder: PC request -> 1-cycle I-mem read -> response FIFO; accept-to-rsp 2 cycles (1 with IFETCH_BYPASS_EN).
// req_ready is credit based (fifo count + in-flight vs DEPTH), low during flush and reset.
module ifetch_resp
  import ifetch_pkg::*;
#(
  parameter int XLEN  = FETCH_XLEN,
  parameter int ILEN  = FETCH_ILEN,
  parameter int DEPTH = 2
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [XLEN-1:0] req_addr,
  input  logic            flush,
  output logic            mem_en,
  output logic [XLEN-1:0] mem_addr,
  input  logic [ILEN-1:0] mem_rdata,
  output logic            rsp_valid,
  input  logic            rsp_ready,
  output logic [XLEN-1:0] rsp_pc,
  output logic [ILEN-1:0] rsp_inst,
  output logic            rsp_fault
);

  localparam int CW = $clog2(DEPTH+1);

  logic            inflight;
  logic            flt_q;
  logic [XLEN-1:0] pc_q;

  fetch_entry_t    ret_ent;
  fetch_entry_t    head;
  fetch_entry_t    out_ent;
  logic [CW-1:0]   count;
  logic            fifo_full;
  logic            fifo_empty;
  logic            ret_vld;
  logic            push;
  logic            pop;
  logic            fifo_pop;
  logic            acc;
  logic            misal;
  logic [CW:0]     occ_after;

  // A return landing in a flush cycle belongs to the old path and is dropped
  assign ret_vld = inflight & ~flush;
  assign ret_ent = '{pc: pc_q, inst: (flt_q ? NOP : mem_rdata), fault: flt_q};

`ifdef IFETCH_BYPASS_EN
  logic byp;
  assign byp       = ret_vld & fifo_empty;
  assign rsp_valid = ~fifo_empty | byp;
  assign out_ent   = fifo_empty ? ret_ent : head;
  assign push      = ret_vld & ~(byp & rsp_ready);
`else
  assign rsp_valid = ~fifo_empty;
  assign out_ent   = head;
  assign push      = ret_vld;
`endif

  assign rsp_pc    = out_ent.pc;
  assign rsp_inst  = out_ent.inst;
  assign rsp_fault = out_ent.fault;

  assign pop      = rsp_valid & rsp_ready;
  assign fifo_pop = pop & ~fifo_empty;

  assign occ_after = {1'b0, count} + (CW+1)'(inflight) - (CW+1)'(pop);
  assign req_ready = reset & ~flush & (occ_after < (CW+1)'(DEPTH));

  assign acc      = req_valid & req_ready;
  assign misal    = is_misaligned(req_addr[1:0]);
  assign mem_en   = acc & ~misal;
  assign mem_addr = req_addr;

  always_ff @(posedge clock) begin
    if (!reset) begin
      inflight <= 1'b0;
      flt_q    <= 1'b0;
      pc_q     <= '0;
    end else begin
      // A misaligned accept still takes a credit and returns next cycle as a fault entry
      inflight <= acc;
      if (acc) begin
        pc_q  <= req_addr;
        flt_q <= misal;
      end
    end
  end

  ifetch_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clock    (clock),
    .reset    (reset),
    .push     (push & (~fifo_full | fifo_pop)),
    .push_dat (ret_ent),
    .pop      (fifo_pop),
    .clear    (flush),
    .head     (head),
    .count    (count),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

endmodule

// File: tb/tb_ifetch_resp.sv
// Directed bench for ifetch_resp plus a randomized phase checked against an in-order queue.
module tb_ifetch_resp;

  localparam int DEPTH = 2;
`ifdef IFETCH_BYPASS_EN
  localparam int LAT = 1;
`else
  localparam int LAT = 2;
`endif
  localparam logic [31:0] TB_NOP = 32'h0000_0013;

  logic        clock;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic        flush;
  logic        mem_en;
  logic [31:0] mem_addr;
  logic [31:0] mem_rdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_pc;
  logic [31:0] rsp_inst;
  logic        rsp_fault;

  int passed = 0;
  int total  = 0;

  ifetch_resp #(.XLEN(32), .ILEN(32), .DEPTH(DEPTH)) dut (
    .clock     (clock),
    .reset     (reset),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_addr  (req_addr),
    .flush     (flush),
    .mem_en    (mem_en),
    .mem_addr  (mem_addr),
    .mem_rdata (mem_rdata),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_pc    (rsp_pc),
    .rsp_inst  (rsp_inst),
    .rsp_fault (rsp_fault)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic logic [31:0] memval(input logic [31:0] a);
    case (a)
      32'h0:   return 32'h0050_0093;
      32'h4:   return 32'h0010_8113;
      32'h8:   return 32'h0000_0073;
      default: return {8'h3C, a[23:0]};
    endcase
  endfunction

  // Synchronous instruction memory, one cycle read latency
  initial mem_rdata = 32'h0;
  always @(posedge clock) if (mem_en) mem_rdata <= memval(mem_addr);

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: got %0h, expected %0h", tag, obs, exp);
  endtask

  task automatic nxt();
    @(posedge clock);
    #1;
  endtask

  logic [31:0] q[$];
  logic [31:0] e;
  int          pop_i;

  initial begin
    reset = 1'b0; req_valid = 1'b0; req_addr = 32'h0; flush = 1'b0; rsp_ready = 1'b0;
    nxt(); nxt();

    // reset state
    req_valid = 1'b1; req_addr = 32'h0;
    #3;
    chk("rst_req_ready", req_ready, 0);
    chk("rst_mem_en", mem_en, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    nxt();
    reset = 1'b1; req_valid = 1'b0;
    #3;
    chk("rel_req_ready", req_ready, 1);
    nxt();

    // streaming 0x0,0x4,0x8 with decode always ready
    rsp_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      req_valid = (k < 3);
      req_addr  = 32'(4 * k);
      #3;
      if (k < 3) begin
        chk("st_req_ready", req_ready, 1);
        chk("st_mem_en", mem_en, 1);
        chk("st_mem_addr", mem_addr, 32'(4 * k));
      end
      chk("st_rsp_valid", rsp_valid, (k >= LAT && k < LAT + 3));
      if (k >= LAT && k < LAT + 3) begin
        chk("st_rsp_pc", rsp_pc, 32'(4 * (k - LAT)));
        chk("st_rsp_inst", rsp_inst, memval(32'(4 * (k - LAT))));
        chk("st_rsp_fault", rsp_fault, 0);
      end
      nxt();
    end

    // backpressure: exactly DEPTH accepts, head held stable
    rsp_ready = 1'b0;
    for (int k = 0; k < 6; k++) begin
      req_valid = 1'b1;
      req_addr  = 32'h20 + 32'(4 * k);
      #3;
      chk("bp_req_ready", req_ready, (k < 2));
      if (k == 5) begin
        chk("bp_hold_valid", rsp_valid, 1);
        chk("bp_hold_pc", rsp_pc, 32'h20);
      end
      nxt();
    end
    req_valid = 1'b0; rsp_ready = 1'b1;
    #3;
    chk("dr0_valid", rsp_valid, 1);
    chk("dr0_pc", rsp_pc, 32'h20);
    chk("dr0_inst", rsp_inst, memval(32'h20));
    chk("dr0_req_ready", req_ready, 1);
    nxt();
    #3;
    chk("dr1_valid", rsp_valid, 1);
    chk("dr1_pc", rsp_pc, 32'h24);
    chk("dr1_inst", rsp_inst, memval(32'h24));
    nxt();
    #3;
    chk("dr2_valid", rsp_valid, 0);
    chk("dr2_req_ready", req_ready, 1);
    nxt();

    // flush kills the in-flight 0x10; 0x40 accepted the cycle after
    req_valid = 1'b1; req_addr = 32'h10;
    #3;
    chk("fl_acc", req_ready, 1);
    nxt();
    flush = 1'b1; req_addr = 32'h40;
    #3;
    chk("fl_req_ready", req_ready, 0);
    chk("fl_mem_en", mem_en, 0);
    chk("fl_rsp_valid", rsp_valid, 0);
    nxt();
    flush = 1'b0;
    #3;
    chk("fl2_req_ready", req_ready, 1);
    chk("fl2_mem_en", mem_en, 1);
    chk("fl2_rsp_valid", rsp_valid, 0);
    nxt();
    for (int k = 1; k <= LAT + 1; k++) begin
      req_valid = 1'b0;
      #3;
      chk("fl_post_valid", rsp_valid, (k == LAT));
      if (k == LAT) begin
        chk("fl_post_pc", rsp_pc, 32'h40);
        chk("fl_post_inst", rsp_inst, memval(32'h40));
      end
      nxt();
    end

    // flush of a full FIFO, with a coincident pop
    rsp_ready = 1'b0; req_valid = 1'b1; req_addr = 32'h50;
    #3; chk("ff_acc0", req_ready, 1);
    nxt();
    req_addr = 32'h54;
    #3; chk("ff_acc1", req_ready, 1);
    nxt();
    req_valid = 1'b0;
    nxt();
    flush = 1'b1; rsp_ready = 1'b1;
    #3;
    chk("ff_valid", rsp_valid, 1);
    chk("ff_pc", rsp_pc, 32'h50);
    nxt();
    flush = 1'b0;
    #3;
    chk("ff_empty_valid", rsp_valid, 0);
    chk("ff_req_ready", req_ready, 1);
    nxt();

    // misaligned fetch
    req_valid = 1'b1; req_addr = 32'h6;
    #3;
    chk("ma_req_ready", req_ready, 1);
    chk("ma_mem_en", mem_en, 0);
    nxt();
    for (int k = 1; k <= LAT; k++) begin
      req_valid = 1'b0;
      #3;
      chk("ma_valid", rsp_valid, (k == LAT));
      if (k == LAT) begin
        chk("ma_pc", rsp_pc, 32'h6);
        chk("ma_inst", rsp_inst, TB_NOP);
        chk("ma_fault", rsp_fault, 1);
      end
      nxt();
    end

    // reset with full occupancy
    rsp_ready = 1'b0; req_valid = 1'b1; req_addr = 32'h60;
    #3; chk("mr_acc0", req_ready, 1);
    nxt();
    req_addr = 32'h64;
    #3; chk("mr_acc1", req_ready, 1);
    nxt();
    reset = 1'b0; req_addr = 32'h68;
    #3;
    chk("mr_req_ready", req_ready, 0);
    chk("mr_mem_en", mem_en, 0);
    nxt();
    req_valid = 1'b0;
    #3;
    chk("mr_rsp_valid", rsp_valid, 0);
    nxt();
    reset = 1'b1; rsp_ready = 1'b1; req_valid = 1'b1; req_addr = 32'h70;
    #3;
    chk("mr_acc_new", req_ready, 1);
    nxt();
    for (int k = 1; k <= LAT + 1; k++) begin
      req_valid = 1'b0;
      #3;
      chk("mr_post_valid", rsp_valid, (k == LAT));
      if (k == LAT) begin
        chk("mr_post_pc", rsp_pc, 32'h70);
        chk("mr_post_inst", rsp_inst, memval(32'h70));
      end
      nxt();
    end

    // randomized traffic against an in-order queue of accepted PCs
    for (int i = 0; i < 1506; i++) begin
      if (i < 1500) begin
        req_valid = ($urandom % 4) != 0;
        req_addr  = {20'h0, 10'($urandom_range(0, 1023)), 2'b00};
        if (($urandom % 8) == 0) req_addr[1:0] = 2'($urandom_range(1, 3));
        rsp_ready = ($urandom % 3) != 0;
        flush     = ($urandom % 16) == 0;
      end else begin
        req_valid = 1'b0; rsp_ready = 1'b1; flush = 1'b0;
      end
      #3;
      pop_i = (rsp_valid && rsp_ready) ? 1 : 0;
      chk("rnd_req_ready", req_ready, (!flush && (q.size() - pop_i < DEPTH)));
      if (pop_i == 1) begin
        chk("rnd_q_nonempty", (q.size() != 0), 1);
        if (q.size() != 0) begin
          e = q.pop_front();
          chk("rnd_pc", rsp_pc, e);
          chk("rnd_inst", rsp_inst, (e[1:0] != 2'b00) ? TB_NOP : memval(e));
          chk("rnd_fault", rsp_fault, (e[1:0] != 2'b00));
        end
      end
      if (flush) q.delete();
      else if (req_valid && req_ready) q.push_back(req_addr);
      nxt();
    end
    chk("rnd_drained", q.size(), 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
